snake_key_sched: RTL and testbench
==================================

Name: snake_key_sched

Overview:
Controller between the PS/2 receiver (scancode + one-cycle keyPressed pulse, clk domain) and the snake game engine. It decodes make-codes into direction, pause and restart commands, and buffers direction commands in a small FIFO. It filters illegal turns and releases at most one direction per game tick. It also owns the game run-state (IDLE/RUN/PAUSED/OVER) seen by the engine.

Parameters:
DEPTH, 4, direction FIFO entries (power of 2, >=2)
INIT_DIR, 2'd1, direction after reset/restart (0 up, 1 right, 2 down, 3 left)
DROP_W, 8, width of saturating dropped-command counter

Ports:
clk  input  1  system clock (100 MHz)
rstn  input  1  reset, asynchronous, active-low
key_code  input  8  latched make-code from PS/2 receiver
key_valid  input  1  one-cycle pulse; key_code valid this cycle
game_tick  input  1  one-cycle pulse per snake step from game timer
game_over  input  1  level from engine; collision detected
dir  output  2  current committed direction
step  output  1  one-cycle pulse: engine advances one cell using dir
running  output  1  state==RUN
paused  output  1  state==PAUSED
restart  output  1  one-cycle pulse: engine reinitialises board
q_count  output  clog2(DEPTH)+1  FIFO occupancy
drop_cnt  output  DROP_W  saturating count of rejected/overflowed direction keys

Behaviour:
- Reset: state=IDLE, dir=INIT_DIR, FIFO empty, q_count=0, drop_cnt=0, step=0, restart=0, running=0, paused=0. All outputs are registered.
- Decode, valid only when key_valid=1:
  - UP: 0x75 or 0x1D(W). RIGHT: 0x74 or 0x23(D). DOWN: 0x72 or 0x1B(S). LEFT: 0x6B or 0x1C(A).
  - PAUSE: 0x29 (space). RESTART: 0x76 (Esc).
  - Any other code is ignored and not counted.
- Turn filter: tail = last FIFO entry if q_count>0, else dir. A direction key d is rejected if d==tail or d==tail^2 (reversal).
  - Rejected keys, and keys arriving while the FIFO is full, increment drop_cnt, which saturates at all-ones. The FIFO is unchanged.
- States:
  - IDLE: game_tick ignored.
    - Accepted direction key: push, go to RUN.
    - PAUSE: go to RUN.
    - A rejected key stays in IDLE.
  - RUN:
    - Accepted direction key: push.
    - PAUSE: go to PAUSED.
    - game_over=1: go to OVER. This takes priority over keys in the same cycle.
  - PAUSED:
    - Direction keys ignored (not counted). Ticks ignored.
    - PAUSE: go to RUN.
    - game_over=1: go to OVER.
  - OVER: everything except RESTART ignored; no step.
  - RESTART in any state: next cycle restart=1 for 1 cycle, FIFO flushed, dir=INIT_DIR, state=IDLE; drop_cnt is kept. RESTART wins over a same-cycle tick or game_over.
- Tick (RUN only, and not leaving RUN this cycle):
  - If q_count>0: pop the head; dir = head on the next edge.
  - In all cases step=1 on the next cycle with dir already updated. Latency is tick -> step = 1 clk.
  - An empty FIFO gives a step with dir unchanged.
- Simultaneous push and pop: both occur, and q_count is unchanged.
  - The filter uses the tail before the pop. With q_count==1 the tail is the popped entry.
  - A push when full with a same-cycle pop is still dropped (full is evaluated before the pop).
- Pointers wrap modulo DEPTH. q_count ranges 0..DEPTH.
- Asynchronous reset mid-operation returns everything to the reset values immediately. Pulses in flight are lost.

Test Plan:
1. Reset, key 0x72 (DOWN), then tick: IDLE->RUN; 1 clk after the tick step=1, dir=2, q_count=0.
2. In RUN with dir=1, keys 0x6B (LEFT, reversal), then 0x74 (same): both rejected, drop_cnt=2, q_count=0; next tick gives step with dir=1.
3. dir=1, push UP, LEFT, DOWN, RIGHT, UP (DEPTH=4): the first four are accepted (each legal vs tail) and the 5th dropped, so q_count=4, drop_cnt=1. Four ticks give dir 0,3,2,1.
4. key_valid UP in the same cycle as a tick with q_count=1 (entry DOWN, dir=1): the pop yields dir=2. UP is filtered against DOWN, so it is rejected and drop_cnt increments.
5. Space in RUN -> paused=1; 3 ticks give no step and direction keys are not counted. Space again -> running=1 and the next tick steps.
6. Assert game_over -> OVER; ticks and keys are ignored. Esc in the same cycle as a tick -> restart pulses 1 cycle, dir=1, q_count=0, state IDLE, no step.

Source files
------------

// File: rtl/snake_key_sched.sv
// Snake key scheduler: decodes PS/2 make-codes, queues legal turns and
// releases one direction per game tick while tracking the run state.
module snake_key_sched #(
   parameter int         DEPTH    = 4,
   parameter logic [1:0] INIT_DIR = 2'd1,
   parameter int         DROP_W   = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [7:0]               key_code,
   input  logic                     key_valid,
   input  logic                     game_tick,
   input  logic                     game_over,
   output logic [1:0]               dir,
   output logic                     step,
   output logic                     running,
   output logic                     paused,
   output logic                     restart,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0]     P1   = AW'(1);
   localparam logic [CW-1:0]     C1   = CW'(1);
   localparam logic [CW-1:0]     FULL = CW'(DEPTH);
   localparam logic [DROP_W-1:0] D1   = DROP_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_OVER} state_t;

   state_t            r_state;
   state_t            w_nstate;
   logic [1:0]        r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [CW-1:0]     r_cnt;
   logic [1:0]        r_dir;
   logic              r_step;
   logic              r_running;
   logic              r_paused;
   logic              r_restart;
   logic [DROP_W-1:0] r_drop;

   logic       w_is_dir;
   logic [1:0] w_d;
   logic       w_is_pause;
   logic       w_is_rst;
   logic [1:0] w_tail;
   logic [1:0] w_head;
   logic       w_legal;
   logic       w_dir_evt;
   logic       w_push;
   logic       w_drop;
   logic       w_tick;
   logic       w_pop;

   always_comb begin
      w_is_dir   = 1'b0;
      w_d        = 2'd0;
      w_is_pause = 1'b0;
      w_is_rst   = 1'b0;
      if (key_valid) begin
         case (key_code)
            8'h75, 8'h1D: begin w_is_dir = 1'b1; w_d = 2'd0; end
            8'h74, 8'h23: begin w_is_dir = 1'b1; w_d = 2'd1; end
            8'h72, 8'h1B: begin w_is_dir = 1'b1; w_d = 2'd2; end
            8'h6B, 8'h1C: begin w_is_dir = 1'b1; w_d = 2'd3; end
            8'h29:        w_is_pause = 1'b1;
            8'h76:        w_is_rst   = 1'b1;
            default:      ;
         endcase
      end
   end

   // Turns are judged against the newest queued entry, before any same-cycle pop.
   always_comb begin
      w_tail    = (r_cnt != '0) ? r_mem[r_wr - P1] : r_dir;
      w_head    = r_mem[r_rd];
      w_legal   = (w_d != w_tail) && (w_d != (w_tail ^ 2'd2));
      w_dir_evt = w_is_dir &&
                  ((r_state == S_IDLE) ||
                   ((r_state == S_RUN) && !game_over));
      w_push    = w_dir_evt && w_legal && (r_cnt != FULL);
      w_drop    = w_dir_evt && !(w_legal && (r_cnt != FULL));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      if (w_is_rst) begin
         w_nstate = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:
               if (w_push || w_is_pause) w_nstate = S_RUN;
            S_RUN:
               if (game_over)       w_nstate = S_OVER;
               else if (w_is_pause) w_nstate = S_PAUSED;
            S_PAUSED:
               if (game_over)       w_nstate = S_OVER;
               else if (w_is_pause) w_nstate = S_RUN;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_tick = game_tick && (r_state == S_RUN) && !game_over &&
               !w_is_pause && !w_is_rst;
      w_pop  = w_tick && (r_cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr      <= '0;
         r_rd      <= '0;
         r_cnt     <= '0;
         r_dir     <= INIT_DIR;
         r_step    <= 1'b0;
         r_running <= 1'b0;
         r_paused  <= 1'b0;
         r_restart <= 1'b0;
         r_drop    <= '0;
      end else begin
         r_step    <= w_tick;
         r_restart <= w_is_rst;
         r_running <= (w_nstate == S_RUN);
         r_paused  <= (w_nstate == S_PAUSED);
         if (w_is_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_dir <= INIT_DIR;
         end else begin
            if (w_push) r_wr <= r_wr + P1;
            if (w_pop) begin
               r_rd  <= r_rd + P1;
               r_dir <= w_head;
            end
            case ({w_push, w_pop})
               2'b10:   r_cnt <= r_cnt + C1;
               2'b01:   r_cnt <= r_cnt - C1;
               default: ;
            endcase
         end
         if (w_drop && (r_drop != '1)) r_drop <= r_drop + D1;
      end
   end

   assign dir      = r_dir;
   assign step     = r_step;
   assign running  = r_running;
   assign paused   = r_paused;
   assign restart  = r_restart;
   assign q_count  = r_cnt;
   assign drop_cnt = r_drop;

endmodule

// File: tb/tb_snake_key_sched.sv
// Directed bench for snake_key_sched: hand-computed vectors for
// turns, queueing, pause, game over, restart and saturation.
module tb_snake_key_sched;

   logic       clk;
   logic       rstn;
   logic [7:0] key_code;
   logic       key_valid;
   logic       game_tick;
   logic       game_over;
   logic [1:0] dir;
   logic       step;
   logic       running;
   logic       paused;
   logic       restart;
   logic [2:0] q_count;
   logic [7:0] drop_cnt;

   int n_vec;
   int n_err;

   snake_key_sched dut (
      .clk       (clk),
      .rstn      (rstn),
      .key_code  (key_code),
      .key_valid (key_valid),
      .game_tick (game_tick),
      .game_over (game_over),
      .dir       (dir),
      .step      (step),
      .running   (running),
      .paused    (paused),
      .restart   (restart),
      .q_count   (q_count),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle from a falling edge; outputs are read at the next one.
   task automatic cyc(input logic [7:0] code,
                      input logic kv,
                      input logic tk);
      key_code  = code;
      key_valid = kv;
      game_tick = tk;
      @(negedge clk);
      key_valid = 1'b0;
      game_tick = 1'b0;
   endtask

   task automatic key(input logic [7:0] code);
      cyc(code, 1'b1, 1'b0);
   endtask

   task automatic tick();
      cyc(8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rstn      = 1'b0;
      key_code  = 8'h00;
      key_valid = 1'b0;
      game_tick = 1'b0;
      game_over = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      check("rst_dir", dir, 1);
      check("rst_q", q_count, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_run", running, 0);
      check("rst_pause", paused, 0);
      check("rst_step", step, 0);
      check("rst_restart", restart, 0);

      // IDLE tick is ignored
      tick();
      check("idle_tick_step", step, 0);

      // 1: DOWN starts the game, tick commits it
      key(8'h72);
      check("t1_run", running, 1);
      check("t1_q", q_count, 1);
      tick();
      check("t1_step", step, 1);
      check("t1_dir", dir, 2);
      check("t1_q0", q_count, 0);
      @(negedge clk);
      check("t1_step_off", step, 0);

      key(8'h76);
      check("rs_pulse", restart, 1);
      check("rs_dir", dir, 1);
      check("rs_idle", running, 0);
      @(negedge clk);
      check("rs_pulse_off", restart, 0);

      // 2: pause key starts from IDLE; reversal and same-dir rejected
      key(8'h29);
      check("t2_run", running, 1);
      key(8'h6B);
      key(8'h74);
      check("t2_drop", drop_cnt, 2);
      check("t2_q", q_count, 0);
      key(8'h11);
      check("t2_unknown", drop_cnt, 2);
      tick();
      check("t2_step", step, 1);
      check("t2_dir", dir, 1);

      // 3: fill the queue, overflow drops
      key(8'h75);
      key(8'h6B);
      key(8'h72);
      key(8'h74);
      check("t3_q4", q_count, 4);
      key(8'h75);
      check("t3_full_q", q_count, 4);
      check("t3_drop", drop_cnt, 3);
      tick();
      check("t3_d0", dir, 0);
      check("t3_q3", q_count, 3);
      tick();
      check("t3_d1", dir, 3);
      tick();
      check("t3_d2", dir, 2);
      tick();
      check("t3_d3", dir, 1);
      check("t3_q0", q_count, 0);
      tick();
      check("t3_empty_step", step, 1);
      check("t3_empty_dir", dir, 1);

      // 4: push UP with a same-cycle pop of DOWN (q==1)
      key(8'h1B);
      check("t4_q1", q_count, 1);
      cyc(8'h75, 1'b1, 1'b1);
      check("t4_dir", dir, 2);
      check("t4_step", step, 1);
      check("t4_q", q_count, 0);
      check("t4_drop", drop_cnt, 4);

      // 5: pause blocks ticks and keys
      key(8'h29);
      check("t5_paused", paused, 1);
      check("t5_notrun", running, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_nostep", step, 0);
      end
      key(8'h1C);
      key(8'h1D);
      check("t5_q", q_count, 0);
      check("t5_drop", drop_cnt, 4);
      key(8'h29);
      check("t5_resume", running, 1);
      check("t5_unpaused", paused, 0);
      tick();
      check("t5_step", step, 1);
      check("t5_dir", dir, 2);

      // 6: game over beats tick, then restart beats tick
      game_over = 1'b1;
      tick();
      check("t6_step", step, 0);
      check("t6_over_run", running, 0);
      check("t6_over_pause", paused, 0);
      cyc(8'h1C, 1'b1, 1'b1);
      check("t6_ign_step", step, 0);
      check("t6_ign_q", q_count, 0);
      check("t6_ign_drop", drop_cnt, 4);
      check("t6_ign_dir", dir, 2);
      cyc(8'h76, 1'b1, 1'b1);
      check("t6_restart", restart, 1);
      check("t6_rs_step", step, 0);
      check("t6_rs_dir", dir, 1);
      check("t6_rs_q", q_count, 0);
      check("t6_rs_run", running, 0);
      game_over = 1'b0;
      @(negedge clk);
      check("t6_rs_off", restart, 0);

      // drop counter saturates; IDLE rejects keep state
      for (int i = 0; i < 260; i++) key(8'h23);
      check("sat_drop", drop_cnt, 8'hFF);
      check("sat_idle", running, 0);

      // asynchronous reset mid-operation
      key(8'h1D);
      check("ar_q_pre", q_count, 1);
      #2 rstn = 1'b0;
      #1;
      check("ar_q", q_count, 0);
      check("ar_run", running, 0);
      check("ar_drop", drop_cnt, 0);
      check("ar_dir", dir, 1);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
